// File: rtl/dense_mac_seq.sv
// Dense-layer MAC sequencer. Walks the weight ROM one neuron at a time and
// multiplies each weight by its activation. It emits one accumulated, optionally
// ReLU-clamped result per neuron.
module dense_mac_seq #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int ACT_ADDR_WIDTH = 4,
    parameter int N_IN           = 16,
    parameter int N_OUT          = 4,
    parameter int ACC_WIDTH      = 24,
    parameter int RELU           = 1,
    localparam int IDX_WIDTH     = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      rom_ena,
    output logic [ADDR_WIDTH-1:0]     rom_addr,
    input  logic [DATA_WIDTH-1:0]     rom_q,
    output logic [ACT_ADDR_WIDTH-1:0] act_addr,
    input  logic [DATA_WIDTH-1:0]     act_q,
    output logic                      busy,
    output logic                      out_valid,
    output logic [IDX_WIDTH-1:0]      out_idx,
    output logic [ACC_WIDTH-1:0]      out_data,
    output logic                      done
);

    localparam int PROD_WIDTH = 2 * DATA_WIDTH;
    localparam logic [ACT_ADDR_WIDTH-1:0] I_LAST = ACT_ADDR_WIDTH'(N_IN - 1);
    localparam logic [IDX_WIDTH-1:0]      J_LAST = IDX_WIDTH'(N_OUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [ACT_ADDR_WIDTH-1:0] i_reg;
    logic [IDX_WIDTH-1:0]      j_reg;
    logic [IDX_WIDTH-1:0]      j_d_reg;
    logic [IDX_WIDTH-1:0]      out_idx_reg;
    logic [ADDR_WIDTH-1:0]     rom_addr_reg;
    logic                      rom_ena_reg;
    logic                      v1_reg;
    logic                      last_i_reg;
    logic                      last_j_reg;
    logic                      out_valid_reg;
    logic                      done_reg;
    logic [ACC_WIDTH-1:0]      acc_reg;
    logic [ACC_WIDTH-1:0]      out_data_reg;

    logic                         accept;
    logic                         i_wrap;
    logic                         last_issue;
    logic signed [PROD_WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0]         sum;
    logic [ACC_WIDTH-1:0]         result;

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        i_wrap     = (i_reg == I_LAST);
        last_issue = (state_reg == ISSUE) && i_wrap && (j_reg == J_LAST);
        case (state_reg)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (last_issue) begin
                    state_next = DRAIN;
                end
            end
            // Stay until the final neuron strobes, so a start coinciding with done is ignored
            DRAIN: begin
                if (done_reg) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The signed size cast sign-extends the full-precision product into the accumulator
    assign prod = $signed(rom_q) * $signed(act_q);
    assign sum  = acc_reg + ACC_WIDTH'(prod);

    generate
        if (RELU != 0) begin : g_relu
            assign result = sum[ACC_WIDTH-1] ? '0 : sum;
        end else begin : g_pass
            assign result = sum;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            i_reg         <= '0;
            j_reg         <= '0;
            j_d_reg       <= '0;
            rom_addr_reg  <= '0;
            rom_ena_reg   <= 1'b0;
            v1_reg        <= 1'b0;
            last_i_reg    <= 1'b0;
            last_j_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
            out_idx_reg   <= '0;
            out_data_reg  <= '0;
            done_reg      <= 1'b0;
            acc_reg       <= '0;
        end else begin
            state_reg   <= state_next;
            rom_ena_reg <= (state_next == ISSUE);

            // rom_addr tracks j*N_IN+i as a running count, avoiding a multiplier
            if (accept) begin
                i_reg        <= '0;
                j_reg        <= '0;
                rom_addr_reg <= '0;
            end else if ((state_reg == ISSUE) && !last_issue) begin
                rom_addr_reg <= rom_addr_reg + ADDR_WIDTH'(1);
                if (i_wrap) begin
                    i_reg <= '0;
                    j_reg <= j_reg + IDX_WIDTH'(1);
                end else begin
                    i_reg <= i_reg + ACT_ADDR_WIDTH'(1);
                end
            end

            // Tags travel alongside the read so they line up with rom_q/act_q
            v1_reg     <= rom_ena_reg;
            last_i_reg <= i_wrap;
            last_j_reg <= (j_reg == J_LAST);
            j_d_reg    <= j_reg;

            out_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
            if (accept) begin
                acc_reg <= '0;
            end else if (v1_reg) begin
                if (last_i_reg) begin
                    acc_reg       <= '0;
                    out_valid_reg <= 1'b1;
                    out_data_reg  <= result;
                    out_idx_reg   <= j_d_reg;
                    done_reg      <= last_j_reg;
                end else begin
                    acc_reg <= sum;
                end
            end
        end
    end

    assign rom_ena   = rom_ena_reg;
    assign rom_addr  = rom_addr_reg;
    assign act_addr  = i_reg;
    assign busy      = (state_reg != IDLE);
    assign out_valid = out_valid_reg;
    assign out_idx   = out_idx_reg;
    assign out_data  = out_data_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_dense_mac_seq.sv
// Bench for dense_mac_seq. It runs three configurations against ROM and
// activation models, and compares each result to an arithmetic dot-product model.
module tb_dense_mac_seq;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // A: N_IN=4 N_OUT=2 ACC=16 RELU=0   B: defaults (RELU=1)   C: N_IN=1 N_OUT=4 RELU=0
    logic        start_a, rom_ena_a, busy_a, out_valid_a, done_a;
    logic [7:0]  rom_addr_a, rom_q_a, act_q_a;
    logic [3:0]  act_addr_a;
    logic [0:0]  out_idx_a;
    logic [15:0] out_data_a;

    logic        start_b, rom_ena_b, busy_b, out_valid_b, done_b;
    logic [7:0]  rom_addr_b, rom_q_b, act_q_b;
    logic [3:0]  act_addr_b;
    logic [1:0]  out_idx_b;
    logic [23:0] out_data_b;

    logic        start_c, rom_ena_c, busy_c, out_valid_c, done_c;
    logic [7:0]  rom_addr_c, rom_q_c, act_q_c;
    logic [3:0]  act_addr_c;
    logic [1:0]  out_idx_c;
    logic [23:0] out_data_c;

    dense_mac_seq #(.N_IN(4), .N_OUT(2), .ACC_WIDTH(16), .RELU(0)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .rom_ena(rom_ena_a), .rom_addr(rom_addr_a),
        .rom_q(rom_q_a), .act_addr(act_addr_a), .act_q(act_q_a), .busy(busy_a),
        .out_valid(out_valid_a), .out_idx(out_idx_a), .out_data(out_data_a), .done(done_a));

    dense_mac_seq dut_b (
        .clk(clk), .rst(rst), .start(start_b), .rom_ena(rom_ena_b), .rom_addr(rom_addr_b),
        .rom_q(rom_q_b), .act_addr(act_addr_b), .act_q(act_q_b), .busy(busy_b),
        .out_valid(out_valid_b), .out_idx(out_idx_b), .out_data(out_data_b), .done(done_b));

    dense_mac_seq #(.N_IN(1), .N_OUT(4), .RELU(0)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .rom_ena(rom_ena_c), .rom_addr(rom_addr_c),
        .rom_q(rom_q_c), .act_addr(act_addr_c), .act_q(act_q_c), .busy(busy_c),
        .out_valid(out_valid_c), .out_idx(out_idx_c), .out_data(out_data_c), .done(done_c));

    typedef struct {
        int     dut;
        int     rel;
        int     idx;
        longint data;
        logic   valid;
        logic   done;
    } ev_t;

    ev_t  evq[$];
    ev_t  expq[$];
    int   t0[3];
    int   rom_m[3][256];
    int   act_m[3][16];
    logic tr_busy[64];
    logic tr_ena[64];
    int   tr_addr[64];
    int   n_chk = 0;
    int   n_fail = 0;

    // ROM and activation buffer: one-cycle registered reads
    always @(posedge clk) begin
        if (rom_ena_a) rom_q_a <= 8'(rom_m[0][int'(rom_addr_a)]);
        if (rom_ena_b) rom_q_b <= 8'(rom_m[1][int'(rom_addr_b)]);
        if (rom_ena_c) rom_q_c <= 8'(rom_m[2][int'(rom_addr_c)]);
        act_q_a <= 8'(act_m[0][int'(act_addr_a)]);
        act_q_b <= 8'(act_m[1][int'(act_addr_b)]);
        act_q_c <= 8'(act_m[2][int'(act_addr_c)]);
    end

    always @(negedge clk) begin
        if (out_valid_a || done_a)
            evq.push_back(ev_t'{0, cyc - t0[0], int'(out_idx_a), longint'($signed(out_data_a)), out_valid_a, done_a});
        if (out_valid_b || done_b)
            evq.push_back(ev_t'{1, cyc - t0[1], int'(out_idx_b), longint'($signed(out_data_b)), out_valid_b, done_b});
        if (out_valid_c || done_c)
            evq.push_back(ev_t'{2, cyc - t0[2], int'(out_idx_c), longint'($signed(out_data_c)), out_valid_c, done_c});
        if ((cyc - t0[0]) >= 0 && (cyc - t0[0]) < 64) begin
            tr_busy[cyc - t0[0]] = busy_a;
            tr_ena[cyc - t0[0]]  = rom_ena_a;
            tr_addr[cyc - t0[0]] = int'(rom_addr_a);
        end
    end

    function automatic int nin(input int d);
        return (d == 0) ? 4 : (d == 1) ? 16 : 1;
    endfunction
    function automatic int nout(input int d);
        return (d == 0) ? 2 : 4;
    endfunction
    function automatic int accw(input int d);
        return (d == 0) ? 16 : 24;
    endfunction

    // Dot product in wide integer arithmetic, reduced modulo 2**ACC_WIDTH, then ReLU
    function automatic longint model_val(input int d, input int j);
        longint s;
        longint m;
        longint span;
        s = 0;
        for (int i = 0; i < nin(d); i++)
            s += longint'(rom_m[d][j * nin(d) + i]) * longint'(act_m[d][i]);
        span = longint'(1) <<< accw(d);
        m = s & (span - 1);
        if (m >= (span >>> 1)) m -= span;
        if (d == 1 && m < 0) m = 0;
        return m;
    endfunction

    function automatic void model_pass(input int d, input int base);
        for (int j = 0; j < nout(d); j++)
            expq.push_back(ev_t'{d, base + (j + 1) * nin(d) + 2, j, model_val(d, j), 1'b1, logic'(j == nout(d) - 1)});
    endfunction

    task automatic fill_random(input int d);
        for (int a = 0; a < 256; a++) rom_m[d][a] = int'($urandom_range(255)) - 128;
        for (int i = 0; i < 16; i++) act_m[d][i] = int'($urandom_range(255)) - 128;
    endtask

    task automatic pulse_start(input int d);
        @(posedge clk); #1;
        t0[d] = cyc;
        case (d)
            0: start_a = 1'b1;
            1: start_b = 1'b1;
            default: start_c = 1'b1;
        endcase
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_chk++;
        if (rom_ena_a !== 1'b0 || rom_addr_a !== 8'd0 || act_addr_a !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_rom: ena=%b addr=%0d act_addr=%0d, expected 0 0 0", rom_ena_a, rom_addr_a, act_addr_a);
        end
        n_chk++;
        if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
        n_chk++;
        if (out_valid_a !== 1'b0 || done_a !== 1'b0) begin
            n_fail++; $display("FAIL reset_strobes: valid=%b done=%b expected 0 0", out_valid_a, done_a);
        end
        n_chk++;
        if (out_data_a !== 16'd0 || out_idx_a !== 1'b0) begin
            n_fail++; $display("FAIL reset_data: data=%h idx=%0d expected 0 0", out_data_a, out_idx_a);
        end
    endtask

    task automatic test_basic();
        int ne;
        for (int a = 0; a < 256; a++) rom_m[0][a] = 1;
        for (int i = 0; i < 16; i++) act_m[0][i] = (i < 4) ? i + 1 : 0;
        evq.delete(); expq.delete();
        pulse_start(0);
        repeat (16) @(posedge clk);
        @(negedge clk);
        model_pass(0, 0);
        n_chk++;
        if (evq.size() != expq.size()) begin n_fail++; $display("FAIL basic_count: got %0d events expected %0d", evq.size(), expq.size()); end
        ne = (evq.size() < expq.size()) ? evq.size() : expq.size();
        for (int k = 0; k < ne; k++) begin
            n_chk++;
            if (evq[k].dut !== expq[k].dut || evq[k].rel !== expq[k].rel || evq[k].idx !== expq[k].idx ||
                evq[k].data !== expq[k].data || evq[k].valid !== expq[k].valid || evq[k].done !== expq[k].done) begin
                n_fail++;
                $display("FAIL basic_ev%0d: got cyc=%0d idx=%0d data=%0d v=%b d=%b expected cyc=%0d idx=%0d data=%0d v=%b d=%b", k,
                         evq[k].rel, evq[k].idx, evq[k].data, evq[k].valid, evq[k].done,
                         expq[k].rel, expq[k].idx, expq[k].data, expq[k].valid, expq[k].done);
            end
        end
        for (int r = 1; r <= 9; r++) begin
            n_chk++;
            if (tr_ena[r] !== logic'(r <= 8) || tr_addr[r] != ((r <= 8) ? r - 1 : 7)) begin
                n_fail++;
                $display("FAIL basic_addr_c%0d: ena=%b addr=%0d expected ena=%b addr=%0d", r, tr_ena[r], tr_addr[r], r <= 8, (r <= 8) ? r - 1 : 7);
            end
        end
        for (int r = 0; r <= 12; r++) begin
            n_chk++;
            if (tr_busy[r] !== logic'(r >= 1 && r <= 10)) begin
                n_fail++; $display("FAIL basic_busy_c%0d: got %b expected %b", r, tr_busy[r], r >= 1 && r <= 10);
            end
        end
    endtask

    task automatic test_relu();
        int ne;
        for (int a = 0; a < 8; a++) rom_m[0][a] = (a < 4) ? 1 : -1;
        for (int i = 0; i < 16; i++) act_m[0][i] = (i < 4) ? i + 1 : 0;
        for (int a = 0; a < 256; a++) rom_m[1][a] = (a < 4) ? 1 : (a >= 16 && a < 20) ? -1 : 0;
        for (int i = 0; i < 16; i++) act_m[1][i] = (i < 4) ? i + 1 : 0;
        evq.delete(); expq.delete();
        pulse_start(0);
        repeat (16) @(posedge clk);
        pulse_start(1);
        repeat (72) @(posedge clk);
        @(negedge clk);
        model_pass(0, 0);
        model_pass(1, 0);
        n_chk++;
        if (evq.size() != expq.size()) begin n_fail++; $display("FAIL relu_count: got %0d events expected %0d", evq.size(), expq.size()); end
        ne = (evq.size() < expq.size()) ? evq.size() : expq.size();
        for (int k = 0; k < ne; k++) begin
            n_chk++;
            if (evq[k].dut !== expq[k].dut || evq[k].rel !== expq[k].rel || evq[k].idx !== expq[k].idx ||
                evq[k].data !== expq[k].data || evq[k].valid !== expq[k].valid || evq[k].done !== expq[k].done) begin
                n_fail++;
                $display("FAIL relu_ev%0d: got dut=%0d cyc=%0d idx=%0d data=%0d d=%b expected dut=%0d cyc=%0d idx=%0d data=%0d d=%b", k,
                         evq[k].dut, evq[k].rel, evq[k].idx, evq[k].data, evq[k].done,
                         expq[k].dut, expq[k].rel, expq[k].idx, expq[k].data, expq[k].done);
            end
        end
    endtask

    task automatic test_wrap();
        for (int a = 0; a < 8; a++) rom_m[0][a] = 127;
        for (int i = 0; i < 4; i++) act_m[0][i] = 127;
        evq.delete();
        pulse_start(0);
        repeat (16) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if (evq.size() != 2) begin n_fail++; $display("FAIL wrap_count: got %0d events expected 2", evq.size()); end
        for (int k = 0; k < evq.size() && k < 2; k++) begin
            n_chk++;
            if (evq[k].data != -1020 || evq[k].idx != k) begin
                n_fail++; $display("FAIL wrap_ev%0d: got idx=%0d data=%0d expected idx=%0d data=-1020", k, evq[k].idx, evq[k].data, k);
            end
        end
    endtask

    task automatic test_ignored_start();
        int ne;
        fill_random(0);
        evq.delete(); expq.delete();
        pulse_start(0);
        for (int c = 1; c <= 25; c++) begin
            if (c == 3 || c == 10 || c == 11) start_a = 1'b1;
            @(posedge clk); #1;
            start_a = 1'b0;
        end
        @(negedge clk);
        model_pass(0, 0);
        model_pass(0, 11);
        n_chk++;
        if (evq.size() != expq.size()) begin n_fail++; $display("FAIL ignore_count: got %0d events expected %0d", evq.size(), expq.size()); end
        ne = (evq.size() < expq.size()) ? evq.size() : expq.size();
        for (int k = 0; k < ne; k++) begin
            n_chk++;
            if (evq[k].rel !== expq[k].rel || evq[k].idx !== expq[k].idx || evq[k].data !== expq[k].data ||
                evq[k].valid !== expq[k].valid || evq[k].done !== expq[k].done) begin
                n_fail++;
                $display("FAIL ignore_ev%0d: got cyc=%0d idx=%0d data=%0d d=%b expected cyc=%0d idx=%0d data=%0d d=%b", k,
                         evq[k].rel, evq[k].idx, evq[k].data, evq[k].done, expq[k].rel, expq[k].idx, expq[k].data, expq[k].done);
            end
        end
        n_chk++;
        if (tr_busy[11] !== 1'b0 || tr_busy[12] !== 1'b1) begin
            n_fail++; $display("FAIL ignore_busy: c11=%b c12=%b expected 0 1", tr_busy[11], tr_busy[12]);
        end
    endtask

    task automatic test_reset_mid();
        int ne;
        fill_random(0);
        evq.delete(); expq.delete();
        pulse_start(0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (busy_a !== 1'b0 || rom_ena_a !== 1'b0) begin
            n_fail++; $display("FAIL midrst_idle: busy=%b ena=%b expected 0 0", busy_a, rom_ena_a);
        end
        repeat (20) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if (evq.size() != 0) begin n_fail++; $display("FAIL midrst_quiet: got %0d strobes expected 0", evq.size()); end
        fill_random(0);
        evq.delete();
        pulse_start(0);
        repeat (16) @(posedge clk);
        @(negedge clk);
        model_pass(0, 0);
        n_chk++;
        if (evq.size() != expq.size()) begin n_fail++; $display("FAIL midrst_count: got %0d events expected %0d", evq.size(), expq.size()); end
        ne = (evq.size() < expq.size()) ? evq.size() : expq.size();
        for (int k = 0; k < ne; k++) begin
            n_chk++;
            if (evq[k].rel !== expq[k].rel || evq[k].idx !== expq[k].idx || evq[k].data !== expq[k].data || evq[k].done !== expq[k].done) begin
                n_fail++;
                $display("FAIL midrst_ev%0d: got cyc=%0d idx=%0d data=%0d expected cyc=%0d idx=%0d data=%0d", k,
                         evq[k].rel, evq[k].idx, evq[k].data, expq[k].rel, expq[k].idx, expq[k].data);
            end
        end
    endtask

    task automatic test_n_in1();
        for (int a = 0; a < 4; a++) rom_m[2][a] = a + 1;
        act_m[2][0] = -3;
        evq.delete();
        pulse_start(2);
        repeat (10) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if (evq.size() != 4) begin n_fail++; $display("FAIL nin1_count: got %0d events expected 4", evq.size()); end
        for (int k = 0; k < evq.size() && k < 4; k++) begin
            n_chk++;
            if (evq[k].rel != k + 3 || evq[k].idx != k || evq[k].data != -3 * (k + 1) || evq[k].done !== logic'(k == 3)) begin
                n_fail++;
                $display("FAIL nin1_ev%0d: got cyc=%0d idx=%0d data=%0d d=%b expected cyc=%0d idx=%0d data=%0d d=%b", k,
                         evq[k].rel, evq[k].idx, evq[k].data, evq[k].done, k + 3, k, -3 * (k + 1), k == 3);
            end
        end
    endtask

    task automatic test_back_to_back();
        int ne;
        fill_random(2);
        evq.delete(); expq.delete();
        pulse_start(2);
        for (int c = 1; c <= 16; c++) begin
            if (c == 7) start_c = 1'b1;
            @(posedge clk); #1;
            start_c = 1'b0;
        end
        @(negedge clk);
        model_pass(2, 0);
        model_pass(2, 7);
        n_chk++;
        if (evq.size() != expq.size()) begin n_fail++; $display("FAIL b2b_count: got %0d events expected %0d", evq.size(), expq.size()); end
        ne = (evq.size() < expq.size()) ? evq.size() : expq.size();
        for (int k = 0; k < ne; k++) begin
            n_chk++;
            if (evq[k].rel !== expq[k].rel || evq[k].idx !== expq[k].idx || evq[k].data !== expq[k].data || evq[k].done !== expq[k].done) begin
                n_fail++;
                $display("FAIL b2b_ev%0d: got cyc=%0d idx=%0d data=%0d d=%b expected cyc=%0d idx=%0d data=%0d d=%b", k,
                         evq[k].rel, evq[k].idx, evq[k].data, evq[k].done, expq[k].rel, expq[k].idx, expq[k].data, expq[k].done);
            end
        end
    endtask

    task automatic test_random_relu();
        int ne;
        for (int p = 0; p < 3; p++) begin
            fill_random(1);
            evq.delete(); expq.delete();
            pulse_start(1);
            repeat (72) @(posedge clk);
            @(negedge clk);
            model_pass(1, 0);
            n_chk++;
            if (evq.size() != expq.size()) begin n_fail++; $display("FAIL rand%0d_count: got %0d events expected %0d", p, evq.size(), expq.size()); end
            ne = (evq.size() < expq.size()) ? evq.size() : expq.size();
            for (int k = 0; k < ne; k++) begin
                n_chk++;
                if (evq[k].rel !== expq[k].rel || evq[k].idx !== expq[k].idx || evq[k].data !== expq[k].data || evq[k].done !== expq[k].done) begin
                    n_fail++;
                    $display("FAIL rand%0d_ev%0d: got cyc=%0d idx=%0d data=%0d expected cyc=%0d idx=%0d data=%0d", p, k,
                             evq[k].rel, evq[k].idx, evq[k].data, expq[k].rel, expq[k].idx, expq[k].data);
                end
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        t0[0] = 0; t0[1] = 0; t0[2] = 0;
        for (int d = 0; d < 3; d++) begin
            for (int a = 0; a < 256; a++) rom_m[d][a] = 0;
            for (int i = 0; i < 16; i++) act_m[d][i] = 0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_basic();
        test_relu();
        test_wrap();
        test_ignored_start();
        test_reset_mid();
        test_n_in1();
        test_back_to_back();
        test_random_relu();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
